// File: rtl/data_path.sv
// 32-bit single-bus register datapath: register file, PC/IR/MAR/MDR, Y/Z staging and a 64-bit ALU.
// Define DATAPATH_MUL_EN to include the signed 32x32 multiplier (opcode 01111).
module data_path (
    input  logic        clock,
    input  logic        clear,
    input  logic        PCout,
    input  logic        Zhighout,
    input  logic        Zlowout,
    input  logic        MDRout,
    input  logic        R0out,
    input  logic        R2out,
    input  logic        R3out,
    input  logic        R4out,
    input  logic        R5out,
    input  logic        R6out,
    input  logic        R7out,
    input  logic        MARin,
    input  logic        PCin,
    input  logic        MDRin,
    input  logic        IRin,
    input  logic        Yin,
    input  logic        R0in,
    input  logic        R1in,
    input  logic        R2in,
    input  logic        R3in,
    input  logic        R4in,
    input  logic        R5in,
    input  logic        R6in,
    input  logic        R7in,
    input  logic        R8in,
    input  logic        R9in,
    input  logic        R10in,
    input  logic        R11in,
    input  logic        R12in,
    input  logic        R13in,
    input  logic        R14in,
    input  logic        R15in,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        ZHighIn,
    input  logic        ZLowIn,
    input  logic        Cin,
    input  logic        IncPC,
    input  logic        Read,
    input  logic [4:0]  opcode,
    input  logic [31:0] Mdatain,
    output logic [31:0] BusMuxOut,
    output logic [31:0] IR_q,
    output logic [31:0] MAR_q
);

    localparam int unsigned W    = 32;
    localparam int unsigned NREG = 16;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
`ifdef DATAPATH_MUL_EN
    localparam logic [4:0] OP_MUL  = 5'b01111;
`endif

    logic [W-1:0]    r [NREG];
    logic [NREG-1:0] r_in;
    logic [W-1:0]    pc, mdr, y, hi, lo, c, zhigh, zlow;
    logic [2*W-1:0]  alu_r;
    logic [2*W-1:0]  ror_w, rol_w;
    logic [4:0]      sh;

    assign r_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

    // Fixed-priority bus driver; an undriven or unknown select never wins.
    always_comb begin
        BusMuxOut = '0;
        if      (Zhighout) BusMuxOut = zhigh;
        else if (Zlowout)  BusMuxOut = zlow;
        else if (PCout)    BusMuxOut = pc;
        else if (MDRout)   BusMuxOut = mdr;
        else if (R0out)    BusMuxOut = r[0];
        else if (R2out)    BusMuxOut = r[2];
        else if (R3out)    BusMuxOut = r[3];
        else if (R4out)    BusMuxOut = r[4];
        else if (R5out)    BusMuxOut = r[5];
        else if (R6out)    BusMuxOut = r[6];
        else if (R7out)    BusMuxOut = r[7];
    end

    assign sh    = BusMuxOut[4:0];
    assign ror_w = {y, y} >> sh;
    assign rol_w = {y, y} << sh;

`ifdef DATAPATH_MUL_EN
    logic signed [2*W-1:0] mul_a, mul_b;
    logic        [2*W-1:0] mul_p;
    assign mul_a = {{W{y[W-1]}}, y};
    assign mul_b = {{W{BusMuxOut[W-1]}}, BusMuxOut};
    assign mul_p = mul_a * mul_b;
`endif

    // ALU: A = Y, B = bus; upper half is zero except for the multiplier.
    always_comb begin
        alu_r = '0;
        case (opcode)
            OP_ADD:  alu_r[W-1:0] = y + BusMuxOut;
            OP_SUB:  alu_r[W-1:0] = y - BusMuxOut;
            OP_AND:  alu_r[W-1:0] = y & BusMuxOut;
            OP_OR:   alu_r[W-1:0] = y | BusMuxOut;
            OP_SHR:  alu_r[W-1:0] = y >> sh;
            OP_SHRA: alu_r[W-1:0] = W'($signed(y) >>> sh);
            OP_SHL:  alu_r[W-1:0] = y << sh;
            OP_ROR:  alu_r[W-1:0] = ror_w[W-1:0];
            OP_ROL:  alu_r[W-1:0] = rol_w[2*W-1:W];
`ifdef DATAPATH_MUL_EN
            OP_MUL:  alu_r        = mul_p;
`endif
            OP_NEG:  alu_r[W-1:0] = W'(0) - BusMuxOut;
            OP_NOT:  alu_r[W-1:0] = ~BusMuxOut;
            default: alu_r        = '0;
        endcase
    end

    // All registers load from the bus (or ALU/memory) on the edge; clear overrides everything.
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < NREG; i++) r[i] <= '0;
            pc    <= '0;
            IR_q  <= '0;
            MAR_q <= '0;
            mdr   <= '0;
            y     <= '0;
            hi    <= '0;
            lo    <= '0;
            c     <= '0;
            zhigh <= '0;
            zlow  <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (r_in[i]) r[i] <= BusMuxOut;
            end
            if (IncPC)      pc <= pc + W'(1);
            else if (PCin)  pc <= BusMuxOut;
            if (MARin)   MAR_q <= BusMuxOut;
            if (IRin)    IR_q  <= BusMuxOut;
            if (MDRin)   mdr   <= Read ? Mdatain : BusMuxOut;
            if (Yin)     y     <= BusMuxOut;
            if (HIin)    hi    <= BusMuxOut;
            if (LOin)    lo    <= BusMuxOut;
            if (Cin)     c     <= BusMuxOut;
            if (ZLowIn)  zlow  <= alu_r[W-1:0];
            if (ZHighIn) zhigh <= alu_r[2*W-1:W];
        end
    end

    // Registers without a bus driver in this revision.
    logic unused_ok;
    assign unused_ok = ^{r[1], r[8], r[9], r[10], r[11], r[12], r[13], r[14], r[15], hi, lo, c};

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path with a behavioural model checked every cycle.
module tb_data_path;

    logic        clock = 1'b0;
    logic        clear;
    logic [10:0] osel;   // 0 PC, 1 ZH, 2 ZL, 3 MDR, 4 R0, 5..10 R2..R7
    logic [15:0] rin;
    logic        marin, pcin, mdrin, irin, yin, hiin, loin, zhin, zlin, cin, incpc, rd;
    logic [4:0]  opcode;
    logic [31:0] mdatain;
    logic [31:0] bus, ir_q, mar_q;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    always #5 clock = ~clock;

    data_path dut (
        .clock(clock), .clear(clear),
        .PCout(osel[0]), .Zhighout(osel[1]), .Zlowout(osel[2]), .MDRout(osel[3]),
        .R0out(osel[4]), .R2out(osel[5]), .R3out(osel[6]), .R4out(osel[7]),
        .R5out(osel[8]), .R6out(osel[9]), .R7out(osel[10]),
        .MARin(marin), .PCin(pcin), .MDRin(mdrin), .IRin(irin), .Yin(yin),
        .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
        .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
        .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .HIin(hiin), .LOin(loin), .ZHighIn(zhin), .ZLowIn(zlin), .Cin(cin),
        .IncPC(incpc), .Read(rd), .opcode(opcode), .Mdatain(mdatain),
        .BusMuxOut(bus), .IR_q(ir_q), .MAR_q(mar_q)
    );

    // Behavioural model state
    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_lo, m_c, m_zh, m_zl;

    function automatic logic [31:0] m_bus();
        if (osel[1] === 1'b1) return m_zh;
        if (osel[2] === 1'b1) return m_zl;
        if (osel[0] === 1'b1) return m_pc;
        if (osel[3] === 1'b1) return m_mdr;
        if (osel[4] === 1'b1) return m_r[0];
        for (int k = 2; k <= 7; k++)
            if (osel[k+3] === 1'b1) return m_r[k];
        return 32'd0;
    endfunction

    function automatic logic [63:0] m_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = int'(b[4:0]);
        logic [31:0] t = a;
        longint p;
        case (op)
            5'd3:  return {32'd0, a + b};
            5'd4:  return {32'd0, a - b};
            5'd5:  return {32'd0, a & b};
            5'd6:  return {32'd0, a | b};
            5'd7:  begin for (int i = 0; i < n; i++) t = {1'b0, t[31:1]}; return {32'd0, t}; end
            5'd8:  begin for (int i = 0; i < n; i++) t = {t[31], t[31:1]}; return {32'd0, t}; end
            5'd9:  begin for (int i = 0; i < n; i++) t = {t[30:0], 1'b0}; return {32'd0, t}; end
            5'd10: begin for (int i = 0; i < n; i++) t = {t[0], t[31:1]}; return {32'd0, t}; end
            5'd11: begin for (int i = 0; i < n; i++) t = {t[30:0], t[31]}; return {32'd0, t}; end
`ifdef DATAPATH_MUL_EN
            5'd15: begin p = longint'($signed(a)) * longint'($signed(b)); return 64'(p); end
`endif
            5'd17: return {32'd0, 32'd0 - b};
            5'd18: return {32'd0, ~b};
            default: return 64'd0;
        endcase
    endfunction

    always @(posedge clock) begin
        if (clear === 1'b1) begin
            for (int i = 0; i < 16; i++) m_r[i] <= 32'd0;
            m_pc <= 0; m_ir <= 0; m_mar <= 0; m_mdr <= 0; m_y <= 0;
            m_hi <= 0; m_lo <= 0; m_c <= 0; m_zh <= 0; m_zl <= 0;
        end else begin
            for (int i = 0; i < 16; i++)
                if (rin[i] === 1'b1) m_r[i] <= m_bus();
            if (incpc === 1'b1)     m_pc <= m_pc + 32'd1;
            else if (pcin === 1'b1) m_pc <= m_bus();
            if (marin === 1'b1) m_mar <= m_bus();
            if (irin === 1'b1)  m_ir  <= m_bus();
            if (mdrin === 1'b1) m_mdr <= (rd === 1'b1) ? mdatain : m_bus();
            if (yin === 1'b1)   m_y   <= m_bus();
            if (hiin === 1'b1)  m_hi  <= m_bus();
            if (loin === 1'b1)  m_lo  <= m_bus();
            if (cin === 1'b1)   m_c   <= m_bus();
            if (zlin === 1'b1)  m_zl  <= m_alu(opcode, m_y, m_bus()) >> 0;
            if (zhin === 1'b1)  m_zh  <= m_alu(opcode, m_y, m_bus()) >> 32;
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            cmp("model_bus", bus, m_bus());
            cmp("model_ir", ir_q, m_ir);
            cmp("model_mar", mar_q, m_mar);
        end
    end

    task automatic idle();
        clear = 0; osel = '0; rin = '0;
        marin = 0; pcin = 0; mdrin = 0; irin = 0; yin = 0; hiin = 0; loin = 0;
        zhin = 0; zlin = 0; cin = 0; incpc = 0; rd = 0; opcode = '0; mdatain = '0;
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
        idle();
    endtask

    function automatic int sidx(input int k);
        return (k == 0) ? 4 : k + 3;
    endfunction

    task automatic load_reg(input int k, input logic [31:0] v);
        mdatain = v; rd = 1; mdrin = 1;
        nxt();
        osel[3] = 1; rin[k] = 1;
        nxt();
    endtask

    task automatic rd_reg(input int k, input string nm, input logic [31:0] exp);
        osel[sidx(k)] = 1;
        @(negedge clock);
        cmp(nm, bus, exp);
        nxt();
    endtask

    task automatic rd_sel(input int s, input string nm, input logic [31:0] exp);
        osel[s] = 1;
        @(negedge clock);
        cmp(nm, bus, exp);
        nxt();
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;
    vec_t tbl [15];
    logic [31:0] mul_hi_exp, mul_lo_exp;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        clear = 1;
        @(posedge clock); @(posedge clock); #1;
        idle();
        chk_en = 1;

        // Reset state
        @(negedge clock);
        cmp("rst_bus", bus, 32'd0);
        cmp("rst_ir", ir_q, 32'd0);
        cmp("rst_mar", mar_q, 32'd0);
        nxt();
        rd_sel(0, "rst_pc", 32'd0);

        // Memory -> MDR -> R4
        mdatain = 32'h12; rd = 1; mdrin = 1;
        nxt();
        osel[3] = 1; rin[4] = 1;
        @(negedge clock);
        cmp("mdr_bus", bus, 32'h12);
        nxt();
        rd_reg(4, "r4_load", 32'h12);

        // ADD 0x7F + 0x01
        load_reg(3, 32'h7F);
        load_reg(7, 32'h01);
        osel[sidx(3)] = 1; yin = 1;
        nxt();
        osel[sidx(7)] = 1; opcode = 5'b00011; zlin = 1; zhin = 1;
        nxt();
        osel[2] = 1; rin[4] = 1;
        @(negedge clock);
        cmp("add_zlo", bus, 32'h80);
        nxt();
        rd_reg(4, "add_r4", 32'h80);
        rd_sel(1, "add_zhi", 32'd0);

        // Fetch: PC drives bus over MDR, IncPC beats PCin
        osel[0] = 1; osel[3] = 1; marin = 1; incpc = 1; pcin = 1;
        @(negedge clock);
        cmp("fetch_bus", bus, 32'd0);
        nxt();
        osel[0] = 1; marin = 1; incpc = 1;
        @(negedge clock);
        cmp("fetch_pc1", bus, 32'd1);
        cmp("fetch_mar0", mar_q, 32'd0);
        nxt();
        osel[0] = 1;
        @(negedge clock);
        cmp("fetch_pc2", bus, 32'd2);
        cmp("fetch_mar1", mar_q, 32'd1);
        nxt();

        // IR load
        mdatain = 32'h1A1B8000; rd = 1; mdrin = 1;
        nxt();
        osel[3] = 1; irin = 1;
        nxt();
        @(negedge clock);
        cmp("ir_load", ir_q, 32'h1A1B8000);
        nxt();

        // MUL -1 * 2
`ifdef DATAPATH_MUL_EN
        mul_hi_exp = 32'hFFFFFFFF; mul_lo_exp = 32'hFFFFFFFE;
`else
        mul_hi_exp = 32'd0; mul_lo_exp = 32'd0;
`endif
        load_reg(2, 32'hFFFFFFFF);
        load_reg(5, 32'd2);
        osel[sidx(2)] = 1; yin = 1;
        nxt();
        osel[sidx(5)] = 1; opcode = 5'b01111; zlin = 1; zhin = 1;
        nxt();
        rd_sel(1, "mul_hi", mul_hi_exp);
        rd_sel(2, "mul_lo", mul_lo_exp);

        // ALU table with A = 0x80000001
        tbl = '{
            '{5'd7,  32'd4,        32'h08000000},
            '{5'd8,  32'd4,        32'hF8000000},
            '{5'd9,  32'd4,        32'h00000010},
            '{5'd9,  32'h24,       32'h00000010},
            '{5'd10, 32'd4,        32'h18000000},
            '{5'd11, 32'd4,        32'h00000018},
            '{5'd10, 32'd0,        32'h80000001},
            '{5'd7,  32'd0,        32'h80000001},
            '{5'd3,  32'h7FFFFFFF, 32'h00000000},
            '{5'd4,  32'd2,        32'h7FFFFFFF},
            '{5'd5,  32'hFF,       32'h00000001},
            '{5'd6,  32'hF0,       32'h800000F1},
            '{5'd17, 32'd1,        32'hFFFFFFFF},
            '{5'd0,  32'd5,        32'h00000000},
            '{5'd18, 32'd0,        32'hFFFFFFFF}
        };
        load_reg(2, 32'h80000001);
        osel[sidx(2)] = 1; yin = 1;
        nxt();
        for (int i = 0; i < 15; i++) begin
            load_reg(6, tbl[i].b);
            osel[sidx(6)] = 1; opcode = tbl[i].op; zlin = 1; zhin = 1;
            nxt();
            rd_sel(2, $sformatf("alu_op%0d_b%0h", tbl[i].op, tbl[i].b), tbl[i].e);
        end

        // Bus priority
        osel = 11'h7FD;
        @(negedge clock); cmp("prio_zlo", bus, 32'hFFFFFFFF); nxt();
        osel = 11'h7F9;
        @(negedge clock); cmp("prio_pc", bus, 32'd2); nxt();
        osel = 11'h7E0;
        @(negedge clock); cmp("prio_r2", bus, 32'h80000001); nxt();

        // Self-load keeps old value; unknown enable does not load
        osel[sidx(3)] = 1; rin[3] = 1;
        nxt();
        rd_reg(3, "self_load", 32'h7F);
        osel[sidx(3)] = 1; rin[5] = 1'bx;
        nxt();
        rd_reg(5, "x_enable", 32'd2);

        // Clear with everything enabled
        clear = 1; osel = '1; rin = '1;
        marin = 1; pcin = 1; mdrin = 1; irin = 1; yin = 1; hiin = 1; loin = 1;
        zhin = 1; zlin = 1; cin = 1; incpc = 1; rd = 1; opcode = 5'd3; mdatain = 32'hDEADBEEF;
        nxt();
        @(negedge clock);
        cmp("clr_ir", ir_q, 32'd0);
        cmp("clr_mar", mar_q, 32'd0);
        nxt();
        rd_reg(4, "clr_r4", 32'd0);
        rd_reg(2, "clr_r2", 32'd0);
        rd_sel(0, "clr_pc", 32'd0);
        rd_sel(3, "clr_mdr", 32'd0);
        rd_sel(2, "clr_zlo", 32'd0);
        rd_sel(1, "clr_zhi", 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
